// File: rtl/ram_readback_scanner_if.sv
// rtl/ram_readback_scanner_if.sv - control, RAM read port, word stream and status bundle for the readback scanner
interface ram_readback_scanner_if #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 11
);
   logic              Start;
   logic [ADDR_W-1:0] Start_ADDR;
   logic [CNT_W-1:0]  Count;
   logic [ADDR_W-1:0] ADDR;
   logic              rden;
   logic [15:0]       Data_from_SRAM;
   logic [15:0]       Data_out;
   logic [ADDR_W-1:0] Data_ADDR;
   logic              Data_valid;
   logic [15:0]       Checksum;
   logic [15:0]       Xor_sig;
   logic              Busy;
   logic              Done;

   modport master (
      input  Start, Start_ADDR, Count, Data_from_SRAM,
      output ADDR, rden, Data_out, Data_ADDR, Data_valid, Checksum, Xor_sig, Busy, Done
   );

   modport slave (
      output Start, Start_ADDR, Count, Data_from_SRAM,
      input  ADDR, rden, Data_out, Data_ADDR, Data_valid, Checksum, Xor_sig, Busy, Done
   );
endinterface

// File: rtl/ram_readback_scanner.sv
// rtl/ram_readback_scanner.sv - sweeps a RAM address range, streams each word and accumulates sum/XOR signatures
module ram_readback_scanner #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 11,
   parameter int RD_LAT = 1
) (
   input logic                    Clk,
   input logic                    Reset,
   ram_readback_scanner_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              clear_totals;
   logic              issue;

   logic [RD_LAT-1:0] tag_v_q;
   logic [ADDR_W-1:0] tag_a_q [RD_LAT];
   logic [15:0]       dout_q, sum_q, xor_q;
   logic [ADDR_W-1:0] daddr_q;
   logic              dvalid_q;
   logic              ret;

   // the oldest tag slot marks the edge on which q belongs to an issued address
   assign ret = tag_v_q[RD_LAT-1];

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      clear_totals = 1'b0;
      issue        = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.Start) begin
               addr_d       = bus.Start_ADDR;
               rem_d        = bus.Count;
               clear_totals = 1'b1;
               state_d      = (bus.Count == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            issue  = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (tag_v_q == '0) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         tag_v_q  <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_a_q[i] <= '0;
         dout_q   <= '0;
         daddr_q  <= '0;
         dvalid_q <= 1'b0;
         sum_q    <= '0;
         xor_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         tag_v_q[0] <= issue;
         tag_a_q[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_a_q[i] <= tag_a_q[i-1];
         end
         dvalid_q <= ret;
         if (ret) begin
            dout_q  <= bus.Data_from_SRAM;
            daddr_q <= tag_a_q[RD_LAT-1];
         end
         if (clear_totals) begin
            sum_q <= '0;
            xor_q <= '0;
         end else if (ret) begin
            sum_q <= sum_q + bus.Data_from_SRAM;
            xor_q <= xor_q ^ bus.Data_from_SRAM;
         end
      end
   end

   assign bus.ADDR       = addr_q;
   assign bus.rden       = (state_q == ISSUE);
   assign bus.Busy       = (state_q == ISSUE) || (state_q == DRAIN);
   assign bus.Done       = (state_q == DONE);
   assign bus.Data_out   = dout_q;
   assign bus.Data_ADDR  = daddr_q;
   assign bus.Data_valid = dvalid_q;
   assign bus.Checksum   = sum_q;
   assign bus.Xor_sig    = xor_q;
endmodule
